// File: rtl/regfile_dump_if.sv
// Byte stream bus used by the register dump engine.
// The master offers tx_data/tx_valid and the sink answers with tx_ready.
interface regfile_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// Debug readout engine: walks every architectural register and emits
// a framed byte stream (marker, index+data groups, XOR checksum).
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    regfile_dump_if.master    tx,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MARK = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] SEND = 3'd3;
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [2:0]        bcnt;
    logic [7:0]        csum;
    logic [39:0]       shreg;
    logic              xfer;
    logic              last_byte;
    logic              last_reg;

    assign xfer      = tx.tx_valid && tx.tx_ready;
    assign last_byte = (bcnt == 3'd4);
    assign last_reg  = (idx == ADDR_W'(NUM_REGS - 1));

    // Frame sequencer: snapshot one register per LOAD, shift it out in SEND.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            bcnt  <= '0;
            csum  <= '0;
            shreg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= MARK;
                end
                MARK: begin
                    if (xfer) begin
                        state <= LOAD;
                        idx   <= '0;
                        csum  <= '0;
                    end
                end
                LOAD: begin
                    shreg <= {8'(idx), rd_data};
                    bcnt  <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        csum  <= csum ^ shreg[39:32];
                        shreg <= {shreg[31:0], 8'h00};
                        bcnt  <= bcnt + 3'd1;
                        if (last_byte) begin
                            if (last_reg) begin
                                state <= CHK;
                            end else begin
                                state <= LOAD;
                                idx   <= idx + ADDR_W'(1);
                            end
                        end
                    end
                end
                CHK: begin
                    if (xfer) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stream outputs depend on state only, never on tx_ready.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        unique case (state)
            MARK: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = 8'hA5;
            end
            SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = shreg[39:32];
            end
            CHK: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = csum;
            end
            default: begin
            end
        endcase
    end

    // idx only moves at frame start and register steps, so rd_addr
    // naturally holds its last value outside LOAD.
    assign rd_addr = idx;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule
